// File: rtl/cr_huf_comp_bits_acc.sv
// rtl/cr_huf_comp_bits_acc.sv - per-frame encoded-bit totals for ret/pre/sim Huffman tables
// Two-stage pipeline: stage 1 forms freq*len products, stage 2 saturating-accumulates them.
`define CR_HUF_COMP_BITS_W 24

module cr_huf_comp_bits_acc #(
  parameter int FREQ_W = 16,
  parameter int LEN_W  = 5,
  parameter int BITS_W = `CR_HUF_COMP_BITS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hist_vld,
  output logic              hist_rdy,
  input  logic [FREQ_W-1:0] hist_freq,
  input  logic [LEN_W-1:0]  hist_len_ret,
  input  logic [LEN_W-1:0]  hist_len_pre,
  input  logic [LEN_W-1:0]  hist_len_sim,
  input  logic              hist_last,
  input  logic [BITS_W-1:0] sim_hdr_bits,
  output logic              bits_vld,
  input  logic              bits_rdy,
  output logic [BITS_W-1:0] ret_bits,
  output logic [BITS_W-1:0] pre_bits,
  output logic [BITS_W-1:0] sim_bits
);

  localparam int P_W   = FREQ_W + LEN_W;
  localparam int SUM_W = ((P_W > BITS_W) ? P_W : BITS_W) + 1;
  localparam int NT    = 3;  // 0 = ret, 1 = pre, 2 = sim

  localparam logic [SUM_W-1:0]  SUM_MAX  = {{(SUM_W-BITS_W){1'b0}}, {BITS_W{1'b1}}};
  localparam logic [BITS_W-1:0] ALL_ONES = {BITS_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t            state;
  logic              first_pend;
  logic              accept;

  logic              s1_vld;
  logic              s1_first;
  logic              s1_last;
  logic [P_W-1:0]    s1_p    [NT];
  logic [NT-1:0]     s1_unc;
  logic [BITS_W-1:0] s1_hdr;

  logic [LEN_W-1:0]  len_in  [NT];
  logic [BITS_W-1:0] acc     [NT];
  logic [BITS_W-1:0] acc_nxt [NT];
  logic [BITS_W-1:0] base    [NT];
  logic [SUM_W-1:0]  sum     [NT];

  assign len_in[0] = hist_len_ret;
  assign len_in[1] = hist_len_pre;
  assign len_in[2] = hist_len_sim;

  assign hist_rdy = (state == ST_ACC);
  assign bits_vld = (state == ST_OUT);
  assign accept   = hist_vld & hist_rdy;

  assign ret_bits = acc[0];
  assign pre_bits = acc[1];
  assign sim_bits = acc[2];

  // Clamping a non-negative add keeps all-ones sticky for the rest of the frame.
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      base[t] = acc[t];
      if (s1_first) begin
        base[t] = (t == NT - 1) ? s1_hdr : '0;
      end
      sum[t] = SUM_W'(base[t]) + SUM_W'(s1_p[t]);
      if (s1_unc[t] || (sum[t] > SUM_MAX)) begin
        acc_nxt[t] = ALL_ONES;
      end else begin
        acc_nxt[t] = sum[t][BITS_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACC;
      first_pend <= 1'b1;
      s1_vld     <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_unc     <= '0;
      s1_hdr     <= '0;
      for (int t = 0; t < NT; t++) begin
        s1_p[t] <= '0;
        acc[t]  <= '0;
      end
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_first   <= first_pend;
        s1_last    <= hist_last;
        s1_hdr     <= sim_hdr_bits;
        first_pend <= 1'b0;
        for (int t = 0; t < NT; t++) begin
          s1_p[t]   <= P_W'(hist_freq) * P_W'(len_in[t]);
          s1_unc[t] <= (hist_freq != '0) && (len_in[t] == '0);
        end
      end

      if (s1_vld) begin
        for (int t = 0; t < NT; t++) begin
          acc[t] <= acc_nxt[t];
        end
      end

      case (state)
        ST_ACC: begin
          if (accept && hist_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The last beat sits in stage 1 here and lands in acc on this edge.
          if (s1_vld && s1_last) begin
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bits_rdy) begin
            state      <= ST_ACC;
            first_pend <= 1'b1;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

`undef CR_HUF_COMP_BITS_W
